// File: rtl/trans_drain.sv
// trans_drain: round-robin drain of four upstream queues into one egress FIFO, with per-channel delivery counters.
// Latency: pop in IDLE, word captured in WAIT (peak one word per 2 cycles); buffer head reaches data_out with no added latency.
// Backpressure: ready_in=0 holds data_out/dest; no pop is issued once occupancy exceeds BUF_DEPTH-2, so the in-flight word always has a slot.
//
// Ports:
//   clk, reset_L                  clock, synchronous active-low reset
//   data_in0..3, valid0..3        upstream words; valid arrives the cycle after the matching pop
//   fifo_empty0..3, pop0..3       upstream empty flags and single-cycle read strobes
//   data_out, dest, valid_out     egress head word, its source channel, and its valid
//   ready_in                      downstream accept (a word is accepted when valid_out && ready_in)
//   req, idx, cnt_out, cnt_valid  counter read: registered reply one cycle after req
//   err                           sticky class-mismatch flag
// Optional feature: define TRANS_DRAIN_CLASS_CHECK_EN to drop words whose top two bits differ
// from their source channel and raise err; otherwise err is tied to 0.
module trans_drain #(
    parameter int DATA_SIZE = 12,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    input  logic                 valid0,
    input  logic                 valid1,
    input  logic                 valid2,
    input  logic                 valid3,
    input  logic                 fifo_empty0,
    input  logic                 fifo_empty1,
    input  logic                 fifo_empty2,
    input  logic                 fifo_empty3,
    output logic                 pop0,
    output logic                 pop1,
    output logic                 pop2,
    output logic                 pop3,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [1:0]           dest,
    output logic                 valid_out,
    input  logic                 ready_in,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic [4:0]           cnt_out,
    output logic                 cnt_valid,
    output logic                 err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [1:0]           ch;
        logic [DATA_SIZE-1:0] word;
    } entry_t;

    state_t               state, state_nxt;
    logic [1:0]           rr, rr_nxt;
    logic [1:0]           sel, sel_nxt;
    logic [1:0]           pick, cand;
    logic                 found;
    logic                 admit;
    logic                 armed;
    logic [3:0]           empty_vec;
    logic [3:0]           valid_vec;
    logic [3:0]           pop_vec;
    logic [DATA_SIZE-1:0] din [4];
    logic [DATA_SIZE-1:0] sel_word;
    logic                 sel_valid;
    logic                 class_ok;
    logic                 wr_en;
    logic                 accept;
    entry_t               mem [BUF_DEPTH];
    entry_t               head;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [OW-1:0]        occ;
    logic [4:0]           cnt [4];

    assign empty_vec = {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};
    assign valid_vec = {valid3, valid2, valid1, valid0};
    assign din[0]    = data_in0;
    assign din[1]    = data_in1;
    assign din[2]    = data_in2;
    assign din[3]    = data_in3;

    // sel is latched at pop time, so in WAIT it names the channel whose word is arriving.
    assign sel_word  = din[sel];
    assign sel_valid = valid_vec[sel];

    // First non-empty channel scanning upward from rr, wrapping modulo 4.
    always_comb begin : rr_pick
        found = 1'b0;
        pick  = rr;
        cand  = rr;
        for (int k = 0; k < 4; k++) begin
            cand = rr + 2'(k);
            if (!found && !empty_vec[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Admitting only at occupancy <= BUF_DEPTH-2 leaves a free slot for the word
    // that lands during WAIT even if nothing drains meanwhile. armed suppresses a
    // pop in the first cycle after reset release.
    assign admit = armed && found && (occ <= OW'(BUF_DEPTH - 2));

`ifdef TRANS_DRAIN_CLASS_CHECK_EN
    assign class_ok = (sel_word[DATA_SIZE-1 -: 2] == sel);
`else
    assign class_ok = 1'b1;
`endif

    always_comb begin : fsm_next
        state_nxt = state;
        rr_nxt    = rr;
        sel_nxt   = sel;
        pop_vec   = 4'b0000;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (admit) begin
                    pop_vec[pick] = 1'b1;
                    sel_nxt       = pick;
                    rr_nxt        = pick + 2'd1;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                state_nxt = IDLE;
                if (sel_valid && class_ok) begin
                    wr_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pops are combinational from state; gating with reset_L keeps them low while reset is held.
    assign pop0 = pop_vec[0] & reset_L;
    assign pop1 = pop_vec[1] & reset_L;
    assign pop2 = pop_vec[2] & reset_L;
    assign pop3 = pop_vec[3] & reset_L;

    // Egress: head entry shown directly; zeroed when empty so reset leaves clean outputs.
    assign head      = mem[rd_ptr];
    assign valid_out = (occ != '0);
    assign data_out  = valid_out ? head.word : '0;
    assign dest      = valid_out ? head.ch : 2'd0;
    assign accept    = valid_out & ready_in;

    always_ff @(posedge clk) begin : ctrl_regs
        if (!reset_L) begin
            state     <= IDLE;
            rr        <= 2'd0;
            sel       <= 2'd0;
            armed     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            cnt_out   <= 5'd0;
            cnt_valid <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                cnt[c] <= 5'd0;
            end
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            sel   <= sel_nxt;
            armed <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (accept) begin
                rd_ptr        <= rd_ptr + PW'(1);
                cnt[head.ch]  <= cnt[head.ch] + 5'd1;
            end
            // Simultaneous write and accept cancel out.
            occ <= occ + OW'(wr_en) - OW'(accept);
            // Counter read returns the value before any accept in the same cycle.
            cnt_valid <= req;
            cnt_out   <= req ? cnt[idx] : 5'd0;
        end
    end

    // Storage has no reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin : buf_write
        if (reset_L && wr_en) begin
            mem[wr_ptr] <= {sel, sel_word};
        end
    end

`ifdef TRANS_DRAIN_CLASS_CHECK_EN
    logic err_q;
    logic err_set;

    assign err_set = (state == WAIT) && sel_valid && !class_ok;

    always_ff @(posedge clk) begin : err_reg
        if (!reset_L) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_trans_drain.sv
// tb_trans_drain: randomized and directed stimulus for trans_drain against a queue-based reference model.
// Upstream queues and the egress scoreboard live in the bench; the DUT is stepped one cycle at a time.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_trans_drain;
    localparam int DS = 12;
    localparam int D  = 4;

    typedef logic [DS-1:0] word_t;
    typedef struct packed {
        logic [1:0] ch;
        word_t      w;
    } ent_t;

    logic           clk = 1'b0;
    logic           reset_L;
    word_t          din_t [4];
    logic [3:0]     vin;
    logic [3:0]     emp;
    logic           pop0, pop1, pop2, pop3;
    word_t          data_out;
    logic [1:0]     dest;
    logic           valid_out;
    logic           ready_in;
    logic           req;
    logic [1:0]     idx;
    logic [4:0]     cnt_out;
    logic           cnt_valid;
    logic           err;

    always #5 clk = ~clk;

    trans_drain #(.DATA_SIZE(DS), .BUF_DEPTH(D)) dut (
        .clk(clk), .reset_L(reset_L),
        .data_in0(din_t[0]), .data_in1(din_t[1]), .data_in2(din_t[2]), .data_in3(din_t[3]),
        .valid0(vin[0]), .valid1(vin[1]), .valid2(vin[2]), .valid3(vin[3]),
        .fifo_empty0(emp[0]), .fifo_empty1(emp[1]), .fifo_empty2(emp[2]), .fifo_empty3(emp[3]),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .data_out(data_out), .dest(dest), .valid_out(valid_out), .ready_in(ready_in),
        .req(req), .idx(idx), .cnt_out(cnt_out), .cnt_valid(cnt_valid), .err(err)
    );

    int    vecs = 0;
    int    miscompares = 0;
    int    cyc = 0;

    // Reference model state
    word_t up_q [4][$];
    ent_t  sb [$];
    ent_t  infl;
    logic  infl_v;
    int    rr_m;
    logic  prev_pop;
    logic  fresh;
    logic  err_m;
    logic  prev_req;
    logic [4:0] exp_cnt;
    int    cnt_m [4];

    // Observation logs of what the DUT actually did
    int    pop_log [$];
    int    pop_time [$];
    ent_t  dlv_log [$];

    function automatic logic class_bad(input ent_t e);
`ifdef TRANS_DRAIN_CLASS_CHECK_EN
        return (e.w[DS-1:DS-2] != e.ch);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_word(input int ch, input word_t w);
        up_q[ch].push_back(w);
        emp[ch] = 1'b0;
    endtask

    function automatic word_t mk_word(input int ch);
        word_t w;
        w = DS'($urandom);
        w[DS-1:DS-2] = 2'(ch);
        return w;
    endfunction

    // One clock of DUT versus model: compare at negedge, advance model to the next edge.
    task automatic step();
        logic [3:0] got_pop;
        logic [3:0] exp_pop;
        int         ch;
        int         c;
        ent_t       e;
        @(negedge clk);
        cyc++;
        got_pop = {pop3, pop2, pop1, pop0};
        for (int k = 0; k < 4; k++) begin
            if (got_pop[k]) begin
                pop_log.push_back(k);
                pop_time.push_back(cyc);
            end
        end
        if (valid_out === 1'b1 && ready_in === 1'b1) dlv_log.push_back({dest, data_out});

        vecs++;
        if (valid_out !== (sb.size() != 0)) begin
            miscompares++;
            $display("FAIL valid_out cyc %0d got %b exp %b", cyc, valid_out, sb.size() != 0);
        end
        if (sb.size() != 0) begin
            vecs++;
            if ({dest, data_out} !== sb[0]) begin
                miscompares++;
                $display("FAIL egress cyc %0d got dest %0d data %h exp dest %0d data %h",
                         cyc, dest, data_out, sb[0].ch, sb[0].w);
            end
        end

        // Arbitration expectation: not in the capture cycle, not right after reset,
        // only with room for the in-flight word; first non-empty from the rotating start.
        exp_pop = 4'b0000;
        ch = -1;
        if (!prev_pop && !fresh && sb.size() <= D - 2) begin
            for (int k = 0; k < 4; k++) begin
                c = (rr_m + k) % 4;
                if (ch < 0 && up_q[c].size() != 0) ch = c;
            end
            if (ch >= 0) exp_pop[ch] = 1'b1;
        end
        vecs++;
        if (got_pop !== exp_pop) begin
            miscompares++;
            $display("FAIL pop cyc %0d got %b exp %b", cyc, got_pop, exp_pop);
        end
        vecs++;
        if (err !== err_m) begin
            miscompares++;
            $display("FAIL err cyc %0d got %b exp %b", cyc, err, err_m);
        end
        vecs++;
        if (cnt_valid !== prev_req || cnt_out !== (prev_req ? exp_cnt : 5'd0)) begin
            miscompares++;
            $display("FAIL cnt_read cyc %0d got v%b %0d exp v%b %0d", cyc, cnt_valid, cnt_out,
                     prev_req, prev_req ? exp_cnt : 5'd0);
        end

        prev_req = req;
        exp_cnt  = 5'(cnt_m[idx]);
        if (sb.size() != 0 && ready_in) begin
            e = sb.pop_front();
            cnt_m[e.ch] = (cnt_m[e.ch] + 1) % 32;
        end
        if (infl_v) begin
            if (class_bad(infl)) err_m = 1'b1;
            else sb.push_back(infl);
            infl_v = 1'b0;
        end
        if (ch >= 0) begin
            infl.ch = 2'(ch);
            infl.w  = up_q[ch].pop_front();
            infl_v  = 1'b1;
            rr_m    = (ch + 1) % 4;
        end
        prev_pop = (ch >= 0);
        fresh    = 1'b0;

        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            vin[k]   = 1'b0;
            din_t[k] = DS'($urandom);
            emp[k]   = (up_q[k].size() == 0);
        end
        if (infl_v) begin
            vin[infl.ch]   = 1'b1;
            din_t[infl.ch] = infl.w;
        end
    endtask

    task automatic apply_reset(input int ncyc);
        logic [25:0] outs;
        reset_L = 1'b0;
        req = 1'b0;
        @(posedge clk);
        #1;
        vin = 4'b0000;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            outs = {pop3, pop2, pop1, pop0, valid_out, data_out, dest, cnt_out, cnt_valid, err};
            vecs++;
            if (outs !== 26'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d got %h exp 0", i, outs);
            end
            @(posedge clk);
            #1;
        end
        sb.delete();
        infl_v = 1'b0; rr_m = 0; err_m = 1'b0; prev_pop = 1'b0;
        prev_req = 1'b0; exp_cnt = 5'd0; fresh = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cnt_m[c] = 0;
            emp[c] = (up_q[c].size() == 0);
        end
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        repeat (3) step();
    endtask

    task automatic test_single_ch2();
        int n;
        apply_reset(2);
        ready_in = 1'b0;
        n = pop_log.size();
        push_word(2, 12'h8A5);
        repeat (6) step();
        vecs++;
        if (pop_log.size() != n + 1 || pop_log[n] != 2) begin
            miscompares++;
            $display("FAIL single_ch2_pops got %0d pops exp one pop2", pop_log.size() - n);
        end
        vecs++;
        if (valid_out !== 1'b1 || data_out !== 12'h8A5 || dest !== 2'd2) begin
            miscompares++;
            $display("FAIL single_ch2_out got v%b %h d%0d exp v1 8a5 d2", valid_out, data_out, dest);
        end
        ready_in = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_round_robin();
        int n;
        int exp_seq [5];
        exp_seq = '{0, 1, 2, 3, 0};
        apply_reset(2);
        ready_in = 1'b1;
        n = pop_log.size();
        for (int c = 0; c < 4; c++) begin
            push_word(c, mk_word(c));
            push_word(c, mk_word(c));
        end
        repeat (18) step();
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (pop_log.size() <= n + i || pop_log[n + i] != exp_seq[i]) begin
                miscompares++;
                $display("FAIL rr_order pop %0d got %0d exp %0d", i,
                         (pop_log.size() > n + i) ? pop_log[n + i] : -1, exp_seq[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            vecs++;
            if (pop_log.size() <= n + i || pop_time[n + i] - pop_time[n + i - 1] != 2) begin
                miscompares++;
                $display("FAIL rr_spacing pop %0d got gap %0d exp 2", i,
                         (pop_log.size() > n + i) ? pop_time[n + i] - pop_time[n + i - 1] : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        int    n;
        word_t w0;
        apply_reset(2);
        ready_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 3; j++) push_word(c, mk_word(c));
        end
        w0 = up_q[0][0];
        n = pop_log.size();
        repeat (20) step();
        vecs++;
        if (pop_log.size() - n != D - 1) begin
            miscompares++;
            $display("FAIL bp_pops got %0d exp %0d", pop_log.size() - n, D - 1);
        end
        vecs++;
        if (data_out !== w0 || dest !== 2'd0 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold got %h d%0d exp %h d0", data_out, dest, w0);
        end
        ready_in = 1'b1;
        repeat (40) step();
        vecs++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain got valid_out %b exp 0", valid_out);
        end
    endtask

    task automatic test_counter();
        apply_reset(2);
        ready_in = 1'b1;
        for (int j = 0; j < 33; j++) push_word(1, mk_word(1));
        repeat (75) step();
        req = 1'b1;
        idx = 2'd1;
        step();
        req = 1'b0;
        vecs++;
        if (cnt_out !== 5'd1 || cnt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL counter_wrap got v%b %0d exp v1 1", cnt_valid, cnt_out);
        end
        step();
        vecs++;
        if (cnt_out !== 5'd0 || cnt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL counter_idle got v%b %0d exp v0 0", cnt_valid, cnt_out);
        end
    endtask

    task automatic test_class();
        int n;
        apply_reset(2);
        ready_in = 1'b1;
        n = dlv_log.size();
        push_word(0, 12'hC00);
        repeat (6) step();
`ifdef TRANS_DRAIN_CLASS_CHECK_EN
        vecs++;
        if (dlv_log.size() != n || err !== 1'b1) begin
            miscompares++;
            $display("FAIL class_drop got %0d delivered err %b exp 0 delivered err 1", dlv_log.size() - n, err);
        end
`else
        vecs++;
        if (dlv_log.size() != n + 1 || dlv_log[n] !== {2'd0, 12'hC00} || err !== 1'b0) begin
            miscompares++;
            $display("FAIL class_pass got %0d delivered err %b exp 1 delivered dest0 c00 err 0",
                     dlv_log.size() - n, err);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int k;
        int hits;
        apply_reset(2);
        ready_in = 1'b1;
        push_word(3, 12'hD3C);
        k = 0;
        while (!prev_pop && k < 6) begin
            step();
            k++;
        end
        vecs++;
        if (!prev_pop) begin
            miscompares++;
            $display("FAIL midwait_timeout got no pop exp pop3 within 6 cycles");
        end
        n = dlv_log.size();
        apply_reset(2);
        repeat (8) step();
        hits = 0;
        for (int i = n; i < dlv_log.size(); i++) if (dlv_log[i].w == 12'hD3C) hits++;
        vecs++;
        if (hits != 0) begin
            miscompares++;
            $display("FAIL midwait_discard got %0d deliveries of d3c exp 0", hits);
        end
    endtask

    task automatic test_random();
        int    ch;
        word_t w;
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, 3);
                if (up_q[ch].size() < 6) begin
                    w = mk_word(ch);
                    if ($urandom_range(0, 15) == 0) w = DS'($urandom);
                    push_word(ch, w);
                end
            end
            ready_in = ($urandom_range(0, 3) != 0);
            req      = ($urandom_range(0, 2) == 0);
            idx      = 2'($urandom_range(0, 3));
            step();
        end
        req = 1'b0;
        ready_in = 1'b1;
        repeat (60) step();
    endtask

    initial begin
        reset_L  = 1'b0;
        ready_in = 1'b0;
        req      = 1'b0;
        idx      = 2'd0;
        vin      = 4'b0000;
        emp      = 4'b1111;
        for (int c = 0; c < 4; c++) din_t[c] = '0;
        test_reset();
        test_single_ch2();
        test_round_robin();
        test_backpressure();
        test_counter();
        test_class();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
